instr_loader: RTL



---
 rtl/instr_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Program loader: takes a byte stream with a 16-bit word-count header, writes the words to
// instruction memory, zero-fills the remaining addresses, then releases the CPU via start_o.
module instr_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_en_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    WORD,
    WRITE,
    FILL,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0]     DEPTH_W   = 16'(DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t state;
  state_t next_state;

  logic [15:0]     count;
  logic [ADDR_W:0] word_idx;
  logic [ADDR_W:0] fill_cnt;
  logic [1:0]      byte_idx;
  logic [31:0]     word_buf;
  logic            load_prev;
  logic            ready_q;

  logic            accept;
  logic            load_rise;
  logic [15:0]     hdr_count;
  logic [ADDR_W:0] next_idx;

  assign byte_ready_o = ready_q;
  assign accept       = byte_valid_i && ready_q;
  assign load_rise    = load_en_i && !load_prev;
  assign hdr_count    = {byte_data_i, count[7:0]};
  assign next_idx     = word_idx + ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    start_o    = 1'b0;
    busy_o     = 1'b1;
    err_o      = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (load_en_i) next_state = HDR0;
      end
      HDR0: begin
        if (accept) next_state = HDR1;
      end
      HDR1: begin
        if (accept) begin
          if (hdr_count > DEPTH_W)   next_state = ERR;
          else if (hdr_count == '0)  next_state = FILL;
          else                       next_state = WORD;
        end
      end
      WORD: begin
        if (accept && byte_idx == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        mem_we_o   = 1'b1;
        mem_addr_o = word_idx[ADDR_W-1:0];
        mem_data_o = word_buf;
        if (16'(next_idx) == count) next_state = (count == DEPTH_W) ? DONE : FILL;
        else                        next_state = WORD;
      end
      FILL: begin
        mem_we_o   = 1'b1;
        mem_addr_o = fill_cnt[ADDR_W-1:0];
        if (fill_cnt == LAST_ADDR) next_state = DONE;
      end
      DONE: begin
        busy_o  = 1'b0;
        start_o = 1'b1;
        if (load_rise) next_state = HDR0;
      end
      ERR: begin
        busy_o = 1'b0;
        err_o  = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath; ready is registered from the next state so it never depends on byte_valid_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count     <= '0;
      word_idx  <= '0;
      fill_cnt  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      load_prev <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      load_prev <= load_en_i;
      ready_q   <= (next_state == HDR0) || (next_state == HDR1) || (next_state == WORD);
      case (state)
        IDLE, DONE: begin
          if (next_state == HDR0) begin
            count    <= '0;
            word_idx <= '0;
            fill_cnt <= '0;
            byte_idx <= '0;
            word_buf <= '0;
          end
        end
        HDR0: begin
          if (accept) count[7:0] <= byte_data_i;
        end
        HDR1: begin
          if (accept) begin
            count[15:8] <= byte_data_i;
            word_idx    <= '0;
            fill_cnt    <= '0;
            byte_idx    <= '0;
          end
        end
        WORD: begin
          if (accept) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= byte_data_i;
            byte_idx                          <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          // The fill counter starts right after the last data word.
          word_idx <= next_idx;
          fill_cnt <= next_idx;
        end
        FILL: begin
          fill_cnt <= fill_cnt + ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
